// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_datapath
//  Purpose  : Execution datapath driven by the control FSM's per-state
//             enables. Holds the program counter, the instruction register,
//             a unified data memory, two operand registers around one
//             add/subtract unit, and an output register. The IR opcode field
//             is returned to the FSM on `operacion`.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1    rising-edge clock
//    rst        in   1    synchronous active-high reset
//    instr      in   IW   instruction word from ROM at address pc
//    enmem      in   1    memory access enable
//    wrmem      in   1    memory write strobe (effective with enmem)
//    enir       in   1    load instruction register
//    enrop1     in   1    load operand register 1 from memory
//    enrop2     in   1    load result register 2 (ALU) and flags
//    enrio      in   1    load output register from memory
//    enpc       in   1    increment program counter
//    seloper    in   1    0 = add, 1 = subtract
//    selmux     in   3    memory address / write-data select
//    ld_en      in   1    boot/test memory write enable
//    ld_addr    in   AW   boot/test write address
//    ld_data    in   DW   boot/test write data
//    pc         out  PW   instruction ROM address
//    operacion  out  2    IR opcode field
//    salida     out  DW   output register
//    carry      out  1    carry (add) / borrow (subtract)
//    zero       out  1    last ALU result was zero
// ============================================================================
module cpu_datapath #(
   parameter  int DW = 8,
   parameter  int AW = 4,
   parameter  int PW = 4,
   localparam int IW = 2 + 3*AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] instr,
   input  logic          enmem,
   input  logic          wrmem,
   input  logic          enir,
   input  logic          enrop1,
   input  logic          enrop2,
   input  logic          enrio,
   input  logic          enpc,
   input  logic          seloper,
   input  logic [2:0]    selmux,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic [PW-1:0] pc,
   output logic [1:0]    operacion,
   output logic [DW-1:0] salida,
   output logic          carry,
   output logic          zero
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [PW-1:0] pc_q,     pc_d;
   logic [IW-1:0] ir_q,     ir_d;
   logic [DW-1:0] rop1_q,   rop1_d;
   logic [DW-1:0] rop2_q,   rop2_d;
   logic [DW-1:0] salida_q, salida_d;
   logic          carry_q,  carry_d;
   logic          zero_q,   zero_d;

   logic [DW-1:0] mem_q [2**AW];

   // ------------------------------------------------------------------------
   // Instruction field decode
   // ------------------------------------------------------------------------
   logic [AW-1:0] w_fld_a;
   logic [AW-1:0] w_fld_b;
   logic [AW-1:0] w_fld_c;

   assign w_fld_a = ir_q[3*AW-1 -: AW];
   assign w_fld_b = ir_q[2*AW-1 -: AW];
   assign w_fld_c = ir_q[AW-1:0];

   // ------------------------------------------------------------------------
   // Memory address / write-data mux. Unused select codes fall back to the
   // A field for reads and never write.
   // ------------------------------------------------------------------------
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic [DW-1:0] w_rdata;
   logic          w_sel_valid;
   logic          w_dp_we;

   always_comb begin
      w_addr      = w_fld_a;
      w_sel_valid = 1'b0;
      case (selmux)
         3'd1: begin w_addr = w_fld_a; w_sel_valid = 1'b1; end
         3'd2: begin w_addr = w_fld_b; w_sel_valid = 1'b1; end
         3'd3: begin w_addr = w_fld_c; w_sel_valid = 1'b1; end
         default: begin w_addr = w_fld_a; w_sel_valid = 1'b0; end
      endcase
   end

   // The result register feeds the C write; moves write operand 1 back out.
   assign w_wdata = (selmux == 3'd3) ? rop2_q : rop1_q;
   assign w_rdata = mem_q[w_addr];
   assign w_dp_we = enmem & wrmem & w_sel_valid;

   // ------------------------------------------------------------------------
   // Add/subtract unit. Operands are zero-extended by one bit so the top bit
   // of the sum is the carry-out, and the top bit of the difference is set
   // exactly when rop1 < rdata (the borrow).
   // ------------------------------------------------------------------------
   logic [DW:0] w_alu;

   always_comb begin
      if (seloper) begin
         w_alu = {1'b0, rop1_q} - {1'b0, w_rdata};
      end else begin
         w_alu = {1'b0, rop1_q} + {1'b0, w_rdata};
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Every enable is independent and reads pre-edge
   // values, so enrop1 together with enrop2 still uses the old rop1.
   // ------------------------------------------------------------------------
   always_comb begin
      pc_d     = pc_q;
      ir_d     = ir_q;
      rop1_d   = rop1_q;
      rop2_d   = rop2_q;
      salida_d = salida_q;
      carry_d  = carry_q;
      zero_d   = zero_q;

      if (enpc)   pc_d     = pc_q + PW'(1);
      if (enir)   ir_d     = instr;
      if (enrop1) rop1_d   = w_rdata;
      if (enrio)  salida_d = w_rdata;
      if (enrop2) begin
         rop2_d  = w_alu[DW-1:0];
         carry_d = w_alu[DW];
         zero_d  = (w_alu[DW-1:0] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= '0;
         ir_q     <= '0;
         rop1_q   <= '0;
         rop2_q   <= '0;
         salida_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         rop1_q   <= rop1_d;
         rop2_q   <= rop2_d;
         salida_q <= salida_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   // ------------------------------------------------------------------------
   // Data memory: contents survive reset, but no write of any kind lands
   // during a reset cycle. The load port overrides a datapath write.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
         end else if (w_dp_we) begin
            mem_q[w_addr] <= w_wdata;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign pc        = pc_q;
   assign operacion = ir_q[IW-1 -: 2];
   assign salida    = salida_q;
   assign carry     = carry_q;
   assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_datapath
//  Purpose  : Self-checking bench for cpu_datapath. Whole instructions are
//             sequenced through the datapath enables and compared against an
//             instruction-level model of memory, pc and flags.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] instr;
   logic        enmem, wrmem, enir, enrop1, enrop2, enrio, enpc, seloper;
   logic [2:0]  selmux;
   logic        ld_en;
   logic [3:0]  ld_addr;
   logic [7:0]  ld_data;
   logic [3:0]  pc;
   logic [1:0]  operacion;
   logic [7:0]  salida;
   logic        carry, zero;

   always #5 clk = ~clk;

   cpu_datapath #(.DW(8), .AW(4), .PW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .enmem     (enmem),
      .wrmem     (wrmem),
      .enir      (enir),
      .enrop1    (enrop1),
      .enrop2    (enrop2),
      .enrio     (enrio),
      .enpc      (enpc),
      .seloper   (seloper),
      .selmux    (selmux),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .pc        (pc),
      .operacion (operacion),
      .salida    (salida),
      .carry     (carry),
      .zero      (zero)
   );

   // Reference model state, instruction level
   int m [16];
   int pc_m;
   int carry_m, zero_m, salida_m;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      enmem = 0; wrmem = 0; enir = 0; enrop1 = 0; enrop2 = 0;
      enrio = 0; enpc = 0; seloper = 0; selmux = 3'd0;
      ld_en = 0; ld_addr = 4'd0; ld_data = 8'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int addr, input int data);
      clr(); ld_en = 1; ld_addr = addr[3:0]; ld_data = data[7:0]; tick();
      clr();
      m[addr] = data & 255;
   endtask

   // Runs one complete instruction. When cf is set, a load-port write to
   // cf_addr collides with the C write of SUM/RES.
   task automatic exec(input int op, input int a, input int b, input int c,
                       input int cf, input int cf_addr, input int cf_data);
      int res;
      instr = {op[1:0], a[3:0], b[3:0], c[3:0]};
      clr(); enir = 1; tick();
      chk("operacion", {30'd0, operacion}, op);
      clr(); enpc = 1; tick();
      pc_m = (pc_m + 1) % 16;
      chk("pc", {28'd0, pc}, pc_m);
      case (op)
         0, 1: begin
            clr(); enmem = 1; selmux = 3'd1; enrop1 = 1; tick();
            clr(); enmem = 1; selmux = 3'd2; enrop2 = 1; seloper = op[0]; tick();
            res     = (op == 0) ? m[a] + m[b] : m[a] - m[b];
            carry_m = (op == 0) ? int'(res > 255) : int'(m[a] < m[b]);
            zero_m  = int'((res & 255) == 0);
            chk("alu_carry", {31'd0, carry}, carry_m);
            chk("alu_zero", {31'd0, zero}, zero_m);
            clr(); enmem = 1; wrmem = 1; selmux = 3'd3;
            if (cf != 0) begin ld_en = 1; ld_addr = cf_addr[3:0]; ld_data = cf_data[7:0]; end
            tick();
            if (cf != 0) m[cf_addr] = cf_data & 255;
            else         m[c] = res & 255;
            clr(); tick();
         end
         2: begin
            clr(); enmem = 1; selmux = 3'd1; enrop1 = 1; tick();
            clr(); enmem = 1; wrmem = 1; selmux = 3'd2; tick();
            m[b] = m[a];
            clr(); tick();
         end
         default: begin
            clr(); enmem = 1; selmux = 3'd1; enrio = 1; tick();
            salida_m = m[a];
            chk("salida", {24'd0, salida}, salida_m);
            clr(); tick();
            chk("salida_hold", {24'd0, salida}, salida_m);
         end
      endcase
      chk("carry_end", {31'd0, carry}, carry_m);
      chk("zero_end", {31'd0, zero}, zero_m);
   endtask

   initial begin
      int saw_zero;
      int res;
      instr = '0;
      clr();

      // ---------------- reset ----------------
      rst = 1; tick();
      rst = 0;
      pc_m = 0; carry_m = 0; zero_m = 0; salida_m = 0;
      load(0, 8'h5A);
      // Reset asserted with every enable and the load port active
      rst = 1; instr = 14'h3FFF;
      enmem = 1; wrmem = 1; enir = 1; enrop1 = 1; enrop2 = 1; enrio = 1;
      enpc = 1; selmux = 3'd3; ld_en = 1; ld_addr = 4'd0; ld_data = 8'hC3;
      tick();
      clr(); rst = 0;
      chk("rst_pc", {28'd0, pc}, 0);
      chk("rst_operacion", {30'd0, operacion}, 0);
      chk("rst_salida", {24'd0, salida}, 0);
      chk("rst_carry", {31'd0, carry}, 0);
      chk("rst_zero", {31'd0, zero}, 0);
      exec(3, 0, 0, 0, 0, 0, 0);   // memory survived reset untouched

      // ---------------- directed instructions ----------------
      load(1, 8'h30); load(2, 8'h25);
      exec(0, 1, 2, 3, 0, 0, 0);
      exec(3, 3, 0, 0, 0, 0, 0);
      load(4, 8'h10); load(5, 8'h11);
      exec(1, 4, 5, 6, 0, 0, 0);
      exec(3, 6, 0, 0, 0, 0, 0);
      load(4, 8'h22); load(5, 8'h22);
      exec(1, 4, 5, 6, 0, 0, 0);
      exec(3, 6, 0, 0, 0, 0, 0);
      load(7, 8'hA5);
      exec(2, 7, 9, 0, 0, 0, 0);
      exec(3, 9, 0, 0, 0, 0, 0);

      // ---------------- pc wrap and IR ----------------
      while (pc_m != 15) begin
         clr(); enpc = 1; tick(); pc_m = (pc_m + 1) % 16;
      end
      saw_zero = 0;
      for (int i = 0; i < 16; i++) begin
         clr(); enpc = 1; tick(); pc_m = (pc_m + 1) % 16;
         if (i == 0) chk("pc_wrap0", {28'd0, pc}, 0);
      end
      clr();
      chk("pc_wrap_full", {28'd0, pc}, 15);
      instr = 14'h3FFF; enir = 1; tick(); clr();
      chk("ir_all_ones", {30'd0, operacion}, 3);

      // ---------------- load-port conflicts ----------------
      load(1, 8'h30); load(2, 8'h25); load(3, 8'h00);
      exec(0, 1, 2, 3, 1, 3, 8'h11);
      exec(3, 3, 0, 0, 0, 0, 0);
      load(8, 8'h66);
      exec(0, 1, 2, 8, 1, 10, 8'h77);
      exec(3, 8, 0, 0, 0, 0, 0);
      exec(3, 10, 0, 0, 0, 0, 0);

      // ---------------- write suppression on invalid selmux ----------------
      load(11, 8'h01); load(12, 8'h40); load(13, 8'h02);
      exec(0, 12, 13, 14, 0, 0, 0);    // rop1 = 0x40, rop2 = 0x42
      instr = {2'b00, 4'd11, 4'd12, 4'd13};
      clr(); enir = 1; tick();
      for (int s = 0; s < 8; s++) begin
         if (s >= 1 && s <= 3) continue;
         clr(); enmem = 1; wrmem = 1; selmux = s[2:0]; tick();
      end
      clr();
      exec(3, 11, 0, 0, 0, 0, 0);
      exec(3, 12, 0, 0, 0, 0, 0);
      exec(3, 13, 0, 0, 0, 0, 0);

      // ---------------- simultaneous enrop1/enrop2 ----------------
      load(4, $urandom_range(0, 255)); load(5, $urandom_range(0, 255));
      instr = {2'b00, 4'd4, 4'd5, 4'd6};
      clr(); enir = 1; tick();
      clr(); enmem = 1; selmux = 3'd1; enrop1 = 1; tick();
      clr(); enmem = 1; selmux = 3'd2; enrop1 = 1; enrop2 = 1; tick();
      res = m[4] + m[5];
      carry_m = int'(res > 255); zero_m = int'((res & 255) == 0);
      chk("fused_carry", {31'd0, carry}, carry_m);
      clr(); enmem = 1; wrmem = 1; selmux = 3'd3; tick();
      m[6] = res & 255;
      clr(); enmem = 1; selmux = 3'd2; enrop2 = 1; tick();  // rop1 now holds mem[5]
      res = m[5] + m[5];
      carry_m = int'(res > 255); zero_m = int'((res & 255) == 0);
      chk("fused2_carry", {31'd0, carry}, carry_m);
      chk("fused2_zero", {31'd0, zero}, zero_m);
      clr();
      exec(3, 6, 0, 0, 0, 0, 0);

      // ---------------- randomized programs ----------------
      for (int i = 0; i < 16; i++) load(i, $urandom_range(0, 255));
      for (int k = 0; k < 40; k++) begin
         int op, a, b, c, cf;
         op = $urandom_range(0, 3);
         a  = $urandom_range(0, 15);
         b  = $urandom_range(0, 15);
         c  = $urandom_range(0, 15);
         cf = int'($urandom_range(0, 7) == 0);
         exec(op, a, b, c, cf, $urandom_range(0, 15), $urandom_range(0, 255));
         exec(3, $urandom_range(0, 15), 0, 0, 0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
